parallel_argmax_tree: RTL and testbench
=======================================

// Module: parallel_argmax_tree
// PURPOSE
//  Pipelined comparator tree that reduces one chunk of LANES signed values per cycle.
//  Each accepted chunk produces its maximum value and local lane index.
//  Also produces a chunk sequence number that counts chunks within the current frame.
//  Sits directly upstream of the serial-parallel argmax stage:
//   - out_idx feeds its in_argmax input.
//   - out_max feeds its in input.
//   - out_valid gates its clock enable.
//  Fully pipelined; accepts one chunk every cycle; no backpressure.
// PARAMETERS
//  WIDTH        8   bit width of each signed lane value
//  LANES        16  lanes per chunk; power of two, >=2 (equals downstream MAX_IN_ARGMAX)
//  IDX_WIDTH    4   width of local index; must equal log2(LANES)
//  CHUNK_WIDTH  4   width of in-frame chunk counter
// PORTS
//  clk        in   1                 clock, rising edge
//  rst        in   1                 reset, synchronous, active-high
//  in_valid   in   1                 in_data/in_last carry a chunk this cycle
//  in_last    in   1                 chunk is the final chunk of its frame
//  in_data    in   LANES*WIDTH       lane i at in_data[i*WIDTH +: WIDTH], signed
//  out_valid  out  1                 result beat present
//  out_last   out  1                 result belongs to final chunk of frame
//  out_max    out  WIDTH             signed maximum of the chunk
//  out_idx    out  IDX_WIDTH         lane index of the maximum
//  out_chunk  out  CHUNK_WIDTH       chunk number within frame (0 = first)
// BEHAVIOUR
//  - Structure: log2(LANES) registered levels.
//    - Level k pairs adjacent candidates {value, index}.
//    - Level k keeps one winner per pair.
//    - Level 0 operates on raw lanes.
//  - Latency: fixed log2(LANES) cycles, in_valid to out_valid (4 at default).
//    - Throughput: 1 chunk/cycle.
//  - Compare: signed. The right candidate wins only if strictly greater than the left.
//    - Ties therefore resolve to the lowest lane index at every level.
//  - Valid handling:
//    - A valid bit shifts through the levels every cycle.
//    - A level's value/index/last/chunk registers load only when its incoming valid = 1.
//    - With in_valid = 0, the outputs hold the last valid result and out_valid = 0.
//  - Chunk counter:
//    - Captured with each accepted chunk as the current count.
//    - Increments by 1 per accepted chunk.
//    - Clears to 0 after an accepted chunk with in_last = 1.
//    - Wraps modulo 2^CHUNK_WIDTH with no error flag.
//    - in_last with in_valid = 0 is ignored.
//  - Reset:
//    - All valid bits are cleared.
//    - out_valid = 0, out_last = 0.
//    - out_max = -2^(WIDTH-1), out_idx = 0, out_chunk = 0.
//    - Chunk counter = 0.
//  - Reset mid-operation:
//    - All in-flight chunks are discarded; none appear on out_valid.
//    - A chunk presented during the rst cycle is dropped.
//  - Width rules:
//    - Index concatenation grows by 1 bit per level; the final index is exactly IDX_WIDTH bits.
//    - No arithmetic is performed on values.
// TESTING
//  1. Hold rst 2 cycles
//     -> out_valid = 0, out_last = 0, out_max = 8'h80, out_idx = 0, out_chunk = 0.
//  2. One chunk: lane5 = +7, other lanes = -3, in_last = 1
//     -> 4 cycles later: out_valid = 1, out_max = 7, out_idx = 5, out_chunk = 0, out_last = 1.
//  3. Tie: lanes 3 and 9 = 8'h7F, others = 0 -> out_max = 127, out_idx = 3.
//  4. All lanes = 8'h80 -> out_max = -128, out_idx = 0.
//     Also: lane15 = 1, others = 0 -> out_idx = 15.
//  5. Back-to-back chunks A, B, C (C with in_last = 1), then D
//     -> outputs on consecutive cycles with out_chunk = 0, 1, 2, 0.
//     -> out_last set only on C.
//     -> After the stream, outputs hold D's values with out_valid = 0.
//  6. Two chunks in flight, rst pulsed 1 cycle
//     -> no out_valid for those chunks.
//     -> The next chunk reports out_chunk = 0 after 4 cycles.

Source files
------------

// File: rtl/parallel_argmax_tree_if.sv
// Chunk-in / result-out bundle for the parallel argmax comparator tree.
// master drives chunks and observes results; slave is the tree itself.
interface parallel_argmax_tree_if #(
  parameter int WIDTH       = 8,
  parameter int LANES       = 16,
  parameter int IDX_WIDTH   = 4,
  parameter int CHUNK_WIDTH = 4
);
  logic                   in_valid;
  logic                   in_last;
  logic [LANES*WIDTH-1:0] in_data;
  logic                   out_valid;
  logic                   out_last;
  logic [WIDTH-1:0]       out_max;
  logic [IDX_WIDTH-1:0]   out_idx;
  logic [CHUNK_WIDTH-1:0] out_chunk;

  modport master (
    output in_valid, in_last, in_data,
    input  out_valid, out_last, out_max, out_idx, out_chunk
  );

  modport slave (
    input  in_valid, in_last, in_data,
    output out_valid, out_last, out_max, out_idx, out_chunk
  );
endinterface

// File: rtl/parallel_argmax_tree.sv
// Pipelined comparator tree: reduces one chunk of LANES signed values per
// cycle to {max, local lane index}, tagged with the chunk's position in its
// frame. One registered level per halving; ties keep the lower lane index.
module parallel_argmax_tree #(
  parameter int WIDTH       = 8,
  parameter int LANES       = 16,
  parameter int IDX_WIDTH   = 4,
  parameter int CHUNK_WIDTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  parallel_argmax_tree_if.slave bus
);
  localparam int LEVELS = $clog2(LANES);
  // Most negative value: reset value of every max register.
  localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [CHUNK_WIDTH-1:0] chunk_cnt_r;

  // In-frame chunk counter: advances per accepted chunk, clears after a last chunk.
  always_ff @(posedge clk) begin
    if (rst) begin
      chunk_cnt_r <= '0;
    end else if (bus.in_valid) begin
      if (bus.in_last) begin
        chunk_cnt_r <= '0;
      end else begin
        chunk_cnt_r <= chunk_cnt_r + CHUNK_WIDTH'(1);
      end
    end
  end

  for (genvar k = 0; k < LEVELS; k++) begin : lvl
    localparam int N = LANES >> (k + 1);

    // Candidates entering this level (2*N of them) and their sideband.
    logic signed [WIDTH-1:0] cand_val_s [2*N];
    logic [IDX_WIDTH-1:0]    cand_idx_s [2*N];
    logic                    cand_valid_s;
    logic                    cand_last_s;
    logic [CHUNK_WIDTH-1:0]  cand_chunk_s;

    // Winners of this level; index bits above k stay zero.
    logic signed [WIDTH-1:0] nxt_val_s [N];
    logic [IDX_WIDTH-1:0]    nxt_idx_s [N];
    logic signed [WIDTH-1:0] val_r [N];
    logic [IDX_WIDTH-1:0]    idx_r [N];
    logic                    valid_r;
    logic                    last_r;
    logic [CHUNK_WIDTH-1:0]  chunk_r;

    if (k == 0) begin : src
      for (genvar j = 0; j < 2*N; j++) begin : ln
        assign cand_val_s[j] = bus.in_data[j*WIDTH +: WIDTH];
        assign cand_idx_s[j] = '0;
      end
      assign cand_valid_s = bus.in_valid;
      assign cand_last_s  = bus.in_last;
      assign cand_chunk_s = chunk_cnt_r;
    end else begin : src
      for (genvar j = 0; j < 2*N; j++) begin : ln
        assign cand_val_s[j] = lvl[k-1].val_r[j];
        assign cand_idx_s[j] = lvl[k-1].idx_r[j];
      end
      assign cand_valid_s = lvl[k-1].valid_r;
      assign cand_last_s  = lvl[k-1].last_r;
      assign cand_chunk_s = lvl[k-1].chunk_r;
    end

    // Pairwise compare: the right candidate wins only when strictly greater,
    // and its winning side contributes index bit k.
    always_comb begin
      for (int j = 0; j < N; j++) begin
        nxt_val_s[j] = cand_val_s[2*j];
        nxt_idx_s[j] = cand_idx_s[2*j];
        if (cand_val_s[2*j+1] > cand_val_s[2*j]) begin
          nxt_val_s[j] = cand_val_s[2*j+1];
          nxt_idx_s[j] = cand_idx_s[2*j+1] | (IDX_WIDTH'(1) << k);
        end else begin
          nxt_val_s[j] = cand_val_s[2*j];
          nxt_idx_s[j] = cand_idx_s[2*j];
        end
      end
    end

    // Level register: valid always shifts, payload loads only with valid.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_r <= 1'b0;
        last_r  <= 1'b0;
        chunk_r <= '0;
        for (int j = 0; j < N; j++) begin
          val_r[j] <= MIN_VAL;
          idx_r[j] <= '0;
        end
      end else begin
        valid_r <= cand_valid_s;
        if (cand_valid_s) begin
          last_r  <= cand_last_s;
          chunk_r <= cand_chunk_s;
          for (int j = 0; j < N; j++) begin
            val_r[j] <= nxt_val_s[j];
            idx_r[j] <= nxt_idx_s[j];
          end
        end
      end
    end
  end

  assign bus.out_valid = lvl[LEVELS-1].valid_r;
  assign bus.out_last  = lvl[LEVELS-1].last_r;
  assign bus.out_max   = lvl[LEVELS-1].val_r[0];
  assign bus.out_idx   = lvl[LEVELS-1].idx_r[0];
  assign bus.out_chunk = lvl[LEVELS-1].chunk_r;
endmodule

// File: tb/tb_parallel_argmax_tree.sv
// Directed bench for parallel_argmax_tree (default parameters, latency 4).
module tb_parallel_argmax_tree;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [127:0] d;

  parallel_argmax_tree_if #(.WIDTH(8), .LANES(16), .IDX_WIDTH(4), .CHUNK_WIDTH(4)) bus ();

  parallel_argmax_tree #(.WIDTH(8), .LANES(16), .IDX_WIDTH(4), .CHUNK_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] v, input logic [31:0] last,
                         input logic [31:0] mx, input logic [31:0] idx, input logic [31:0] ch);
    chk({tag, ".valid"}, {31'd0, bus.out_valid}, v);
    chk({tag, ".last"},  {31'd0, bus.out_last}, last);
    chk({tag, ".max"},   {24'd0, bus.out_max}, mx);
    chk({tag, ".idx"},   {28'd0, bus.out_idx}, idx);
    chk({tag, ".chunk"}, {28'd0, bus.out_chunk}, ch);
  endtask

  // Present one chunk for one cycle, then idle until its result is due.
  task automatic send_one(input logic [127:0] data, input logic last);
    bus.in_data  = data;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    step();
    step();
    step();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;

    // Reset held two cycles.
    step();
    step();
    chk_out("reset", 32'd0, 32'd0, 32'h80, 32'd0, 32'd0);
    rst = 1'b0;

    // Single chunk, lane 5 = +7, others -3; check exact latency.
    d = {16{8'hFD}};
    d[5*8 +: 8] = 8'h07;
    bus.in_data  = d;
    bus.in_last  = 1'b1;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    step();
    step();
    chk("lat3.valid", {31'd0, bus.out_valid}, 32'd0);
    step();
    chk_out("single", 32'd1, 32'd1, 32'h07, 32'd5, 32'd0);
    step();
    chk_out("single_hold", 32'd0, 32'd1, 32'h07, 32'd5, 32'd0);

    // Tie between lanes 3 and 9 resolves to the lower index.
    d = '0;
    d[3*8 +: 8] = 8'h7F;
    d[9*8 +: 8] = 8'h7F;
    send_one(d, 1'b1);
    chk_out("tie", 32'd1, 32'd1, 32'h7F, 32'd3, 32'd0);

    // All lanes at the most negative value.
    send_one({16{8'h80}}, 1'b1);
    chk_out("allmin", 32'd1, 32'd1, 32'h80, 32'd0, 32'd0);

    // Maximum in the highest lane.
    d = '0;
    d[15*8 +: 8] = 8'h01;
    send_one(d, 1'b1);
    chk_out("lane15", 32'd1, 32'd1, 32'h01, 32'd15, 32'd0);

    // Back-to-back A, B, C(last), D.
    d = '0;
    d[0 +: 8] = 8'd10;
    bus.in_data = d; bus.in_last = 1'b0; bus.in_valid = 1'b1;
    step();
    d = {16{8'hFF}};
    d[6*8 +: 8] = 8'd20;
    bus.in_data = d;
    step();
    d = {16{8'h9C}};
    d[12*8 +: 8] = 8'hFB;
    bus.in_data = d; bus.in_last = 1'b1;
    step();
    d = '0;
    d[1*8 +: 8] = 8'd50;
    bus.in_data = d; bus.in_last = 1'b0;
    step();
    chk_out("strm_a", 32'd1, 32'd0, 32'd10, 32'd0, 32'd0);
    bus.in_valid = 1'b0;
    step();
    chk_out("strm_b", 32'd1, 32'd0, 32'd20, 32'd6, 32'd1);
    step();
    chk_out("strm_c", 32'd1, 32'd1, 32'hFB, 32'd12, 32'd2);
    step();
    chk_out("strm_d", 32'd1, 32'd0, 32'd50, 32'd1, 32'd0);
    step();
    chk_out("strm_hold", 32'd0, 32'd0, 32'd50, 32'd1, 32'd0);

    // Two chunks in flight, then a 1-cycle reset with a chunk presented.
    d = {16{8'd9}};
    bus.in_data = d; bus.in_valid = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk_out("midrst", 32'd0, 32'd0, 32'h80, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("flushed.valid", {31'd0, bus.out_valid}, 32'd0);
    end

    // First chunk after reset counts from zero.
    d = '0;
    d[7*8 +: 8] = 8'd3;
    send_one(d, 1'b0);
    chk_out("post_rst", 32'd1, 32'd0, 32'd3, 32'd7, 32'd0);

    // in_last without in_valid must not clear the counter.
    bus.in_last = 1'b1;
    step();
    bus.in_last = 1'b0;
    d = '0;
    d[2*8 +: 8] = 8'd4;
    send_one(d, 1'b0);
    chk_out("last_novalid", 32'd1, 32'd0, 32'd4, 32'd2, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
